// File: rtl/spi_master_cfg_if.sv
// spi_master_cfg_if: user-bus handshake and SPI wire signals of spi_master_cfg.
// "master" is the SPI master block view; "slave" is the user/pin side.
// Optional feature macro: SPI_LOOPBACK_EN adds the loopback select after miso.
interface spi_master_cfg_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CS_COUNT   = 1,
   parameter int CS_SEL_W   = 1
);
   logic                  start;
   logic [CS_SEL_W-1:0]   cs_sel;
   logic [DATA_WIDTH-1:0] data_in;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  ready;
   logic                  done;
   logic                  err;
   logic                  miso;
`ifdef SPI_LOOPBACK_EN
   logic                  loopback;
`endif
   logic                  mosi;
   logic                  sclk;
   logic [CS_COUNT-1:0]   cs;

   modport master (
      input  start, cs_sel, data_in, miso,
`ifdef SPI_LOOPBACK_EN
      input  loopback,
`endif
      output data_out, ready, done, err, mosi, sclk, cs
   );

   modport slave (
      output start, cs_sel, data_in, miso,
`ifdef SPI_LOOPBACK_EN
      output loopback,
`endif
      input  data_out, ready, done, err, mosi, sclk, cs
   );
endinterface

// File: rtl/spi_master_cfg.sv
// spi_master_cfg: parametrised SPI master with generic word width, SCLK divider,
// all four CPOL/CPHA modes and several active-low chip selects.
// Transfer: IDLE -> LEAD (CLK_DIV) -> SHIFT (2*DATA_WIDTH sclk edges) -> TRAIL (CLK_DIV).
// Optional feature macro: SPI_LOOPBACK_EN -- when its loopback input is 1 the receive
// sampler takes the internal mosi instead of the miso pin.
module spi_master_cfg #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 4,
   parameter int CPOL       = 0,
   parameter int CPHA       = 0,
   parameter int CS_COUNT   = 1,
   parameter int CS_SEL_W   = 1
) (
   input logic             clk,
   input logic             rst,
   spi_master_cfg_if.master bus
);
   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int EDGE_W = $clog2(2 * DATA_WIDTH + 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH - 1);
   localparam logic              SCLK_IDLE = (CPOL != 0);

   typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

   state_t                state_q, state_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [EDGE_W-1:0]     edge_q, edge_d;
   logic [DATA_WIDTH-1:0] tx_q, tx_d;
   logic [DATA_WIDTH-1:0] rx_q, rx_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  mosi_q, mosi_d;
   logic                  sclk_q, sclk_d;
   logic [CS_COUNT-1:0]   cs_q, cs_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic samp, sel_ok, tick, lead;

`ifdef SPI_LOOPBACK_EN
   assign samp = bus.loopback ? mosi_q : bus.miso;
`else
   assign samp = bus.miso;
`endif

   assign sel_ok = (32'(bus.cs_sel) < 32'(CS_COUNT));
   assign tick   = (div_q == DIV_LAST);
   // edge_q counts edges already made; even count means the next edge is a leading one
   assign lead   = ~edge_q[0];

   assign bus.data_out = dout_q;
   assign bus.ready    = (state_q == IDLE);
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.mosi     = mosi_q;
   assign bus.sclk     = sclk_q;
   assign bus.cs       = cs_q;

   // State register; reset wins over everything, including a transfer in flight
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         div_q   <= '0;
         edge_q  <= '0;
         tx_q    <= '0;
         rx_q    <= '0;
         dout_q  <= '0;
         mosi_q  <= 1'b0;
         sclk_q  <= SCLK_IDLE;
         cs_q    <= '1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         edge_q  <= edge_d;
         tx_q    <= tx_d;
         rx_q    <= rx_d;
         dout_q  <= dout_d;
         mosi_q  <= mosi_d;
         sclk_q  <= sclk_d;
         cs_q    <= cs_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Next-state: divider pacing, sclk edge generation, shift/sample and handshake pulses
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      edge_d  = edge_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      dout_d  = dout_q;
      mosi_d  = mosi_q;
      sclk_d  = sclk_q;
      cs_d    = cs_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            sclk_d = SCLK_IDLE;
            mosi_d = 1'b0;
            div_d  = '0;
            edge_d = '0;
            if (bus.start) begin
               if (sel_ok) begin
                  tx_d    = bus.data_in;
                  rx_d    = '0;
                  state_d = LEAD;
                  for (int i = 0; i < CS_COUNT; i++)
                     cs_d[i] = (32'(bus.cs_sel) != 32'(i));
                  // mode with CPHA=0 must present the MSB before the first (sampling) edge
                  if (CPHA == 0) mosi_d = bus.data_in[DATA_WIDTH-1];
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         LEAD: begin
            div_d = div_q + 1'b1;
            if (tick) begin
               div_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            div_d = div_q + 1'b1;
            if (tick) begin
               div_d  = '0;
               sclk_d = ~sclk_q;
               edge_d = edge_q + 1'b1;
               if (lead == (CPHA == 0)) begin
                  rx_d = {rx_q[DATA_WIDTH-2:0], samp};
               end else if (CPHA != 0) begin
                  mosi_d = tx_q[DATA_WIDTH-1];
                  tx_d   = tx_q << 1;
               end else if (edge_q != EDGE_LAST) begin
                  // MSB already on the wire, so the next bit sits one below the top
                  mosi_d = tx_q[DATA_WIDTH-2];
                  tx_d   = tx_q << 1;
               end
               if (edge_q == EDGE_LAST) state_d = TRAIL;
            end
         end
         TRAIL: begin
            div_d = div_q + 1'b1;
            if (tick) begin
               div_d   = '0;
               state_d = IDLE;
               cs_d    = '1;
               dout_d  = rx_q;
               done_d  = 1'b1;
               mosi_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: doc/spi_master_cfg.md
Name: spi_master_cfg

Overview:
- Parametrised SPI master: the successor to the fixed 8-bit spi_loop master side.
- Generic data width, SCLK divider, all four CPOL/CPHA modes, and multiple chip-select lines.
- Connects to the processor-unit bus on the user side and to external SPI pins (or the slave PU in loopback benches) on the wire side.

Parameters:
- DATA_WIDTH, 8: bits per transfer word; minimum 2.
- CLK_DIV, 4: clk cycles per SCLK half-period; minimum 2.
- CPOL, 0: SCLK idle level.
- CPHA, 0: 0 = sample on leading edge; 1 = sample on trailing edge.
- CS_COUNT, 1: number of active-low chip selects.
- CS_SEL_W, 1: width of cs_sel; must satisfy 2**CS_SEL_W >= CS_COUNT.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-low reset.
- start  input  1  transfer request; sampled only while ready=1.
- cs_sel  input  CS_SEL_W  target slave index; latched with start.
- data_in  input  DATA_WIDTH  word to transmit; latched with start.
- data_out  output  DATA_WIDTH  last received word; updated on done.
- ready  output  1  block idle and accepting start.
- done  output  1  one-cycle pulse at transfer end.
- err  output  1  one-cycle pulse when start is rejected for cs_sel >= CS_COUNT.
- miso  input  1  serial data from slave.
- mosi  output  1  serial data to slave.
- sclk  output  1  SPI clock.
- cs  output  CS_COUNT  active-low chip selects.

Behaviour:
- Reset (rst=0 at a rising edge) has priority over everything, including mid-transfer. After that edge:
  - ready=1, done=0, err=0, data_out=0, mosi=0, sclk=CPOL, cs all ones.
  - Divider counter and bit counter are 0; state is IDLE.
- IDLE:
  - ready=1, sclk=CPOL.
  - On start=1 with cs_sel < CS_COUNT: latch data_in into the shift register, assert cs[cs_sel]=0, ready<=0, go to LEAD.
  - If CPHA=0, mosi<=data_in MSB on the same edge.
  - On start=1 with cs_sel >= CS_COUNT: err=1 for one cycle, stay in IDLE, no CS asserted.
- LEAD: hold for CLK_DIV cycles, then go to SHIFT.
- SHIFT:
  - sclk toggles every CLK_DIV cycles, giving exactly 2*DATA_WIDTH edges; the first edge is the leading edge.
  - CPHA=0: sample miso on leading edges; shift the next bit onto mosi on trailing edges. The last trailing edge drives no new bit.
  - CPHA=1: drive mosi (MSB first) on leading edges; sample miso on trailing edges.
  - Bit order is MSB first. Received bits shift into the LSB of the receive register.
  - After the final edge, sclk equals CPOL; go to TRAIL.
- TRAIL:
  - Hold for CLK_DIV cycles.
  - Then: cs all ones, data_out<=receive register, done=1 for one cycle, ready=1 in that same cycle, state IDLE.
- Latency:
  - done is high exactly (2*DATA_WIDTH+2)*CLK_DIV cycles after the start-accept edge.
  - For defaults this is 72 cycles.
- Start while ready=0 is ignored: no queueing, no err.
- Back-to-back operation: start asserted in the done cycle (ready=1) is accepted, and a new LEAD begins on the next edge.
- data_out holds its value between transfers and changes only on done.
- data_in and cs_sel are don't-care outside the accept edge.
- mosi holds its last driven bit through TRAIL and returns to 0 in IDLE.

Optional Feature:
- Macro: SPI_LOOPBACK_EN.
- Defined:
  - Adds an input port loopback (1 bit) after miso.
  - When loopback=1, the receive sampler uses the internal mosi instead of the miso pin.
  - The miso pin is ignored; pins still toggle normally.
  - loopback is sampled continuously and must be held stable during a transfer.
- Undefined: no loopback port; miso is always the sample source.

Test Plan:
- Defaults, mode 0, miso tied externally to mosi, start with data_in=8'hA5, cs_sel=0:
  - cs[0] low from the accept edge; 16 sclk edges seen.
  - done exactly 72 cycles later; data_out=8'hA5; cs back to 1; ready=1.
- DATA_WIDTH=16, CLK_DIV=2, CPOL=1, CPHA=1, slave model returning 16'h3C5A, data_in=16'h0F0F:
  - Slave observes 16'h0F0F MSB-first; data_out=16'h3C5A.
  - done 68 cycles after accept; sclk idles high.
- CS_COUNT=3, CS_SEL_W=2:
  - cs_sel=2 -> only cs[2] low during transfer.
  - cs_sel=3 -> err pulse 1 cycle, cs stays 3'b111, ready stays 1, no sclk edge.
- Busy rejection: assert start again with data_in=8'hFF at cycle 10 of a transfer of 8'h12:
  - Ignored; data_out=8'h12 at done; exactly one done pulse.
- Reset mid-transfer: rst=0 at cycle 30 of a transfer:
  - Next edge: cs all ones, sclk=CPOL, data_out=0, ready=1, no done.
  - A new transfer of 8'h5A after rst=1 completes correctly.
- Back-to-back: counter-driven data_in (incremented each done), start held high, 2000 cycles, loopback:
  - Each data_out equals the previous data_in.
  - Accept occurs in every done cycle.
  - With SPI_LOOPBACK_EN and loopback=1, miso pin held 0: same results.
